// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO read and write controllers.
//   - Default address/data widths.
//   - Gray/binary pointer conversion helpers. They work on a fixed maximum
//     width; callers zero-extend narrower pointers in and size-cast the
//     result back. Zero upper bits leave both conversions unchanged.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDRESS_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH    = 8;
    localparam int FIFO_PTR_MAX_W     = 32;

    typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of every Gray bit at or above it.
    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
        fifo_ptr_t b;
        b = g;
        for (int i = 1; i < FIFO_PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// -----------------------------------------------------------------------------
// fifo_out_buf
//   Two-entry output buffer (out register + skid register) between the FIFO
//   memory read port and a valid/ready consumer. The controller guarantees
//   that a load never arrives while both entries are occupied and no pop
//   happens, so no overflow handling is needed here.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (clears valids and out_data)
//   load       in   load_data carries a word returned from memory
//   load_data  in   [DATA_WIDTH-1:0] returned memory word
//   pop        in   consumer takes out_data this cycle (only while out_valid)
//   out_valid  out  out_data holds a valid word
//   out_data   out  [DATA_WIDTH-1:0] head-of-line word
//   skid_valid out  skid register holds a valid word
// -----------------------------------------------------------------------------
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  skid_valid
);

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  load_to_skid;

    // A returning word lands in skid whenever out is still occupied after this
    // cycle: either out is held (no pop), or out is refilled from skid.
    always_comb begin
        load_to_skid = 1'b0;
        if (load) begin
            if (pop) begin
                load_to_skid = skid_valid;
            end else begin
                load_to_skid = out_valid;
            end
        end
    end

    // ---- buffer stage: control and head-of-line data ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= load;
            end else begin
                out_valid <= load;
                if (load) begin
                    out_data <= load_data;
                end
            end
        end else if (load) begin
            if (!out_valid) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else begin
                skid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_to_skid) begin
            skid_data <= load_data;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side controller of the async FIFO (read clock domain only).
//   Compares the synchronized Gray write pointer with the local Gray read
//   pointer to form Empty, issues memory reads (1-cycle latency) while the
//   2-entry output buffer has room, and presents words over valid/ready.
//
// Optional feature (macro FIFO_RD_LEVEL_EN):
//   Adds Rd_level (entries not yet fetched from memory, buffered words
//   excluded) and AEmpty (Rd_level <= AEMPTY_THRESH). Without the macro
//   neither port nor the Gray-to-binary conversion exists.
//
// Ports
//   CLK         in   read-domain clock
//   RST         in   synchronous active-high reset
//   Rq2_Wptr    in   [ADDRESS_WIDTH:0] synchronized Gray write pointer
//   R_en        out  memory read enable
//   R_addr      out  [ADDRESS_WIDTH-1:0] memory read address
//   R_mem_data  in   [DATA_WIDTH-1:0] memory data, valid the cycle after R_en
//   R_ptr       out  [ADDRESS_WIDTH:0] registered Gray read pointer
//   Empty       out  no unread entries in memory
//   Dout        out  [DATA_WIDTH-1:0] output word
//   Dout_valid  out  Dout holds a valid word
//   Dout_ready  in   consumer accepts Dout
//   Rd_level    out  [ADDRESS_WIDTH:0] unfetched entries (FIFO_RD_LEVEL_EN)
//   AEmpty      out  almost-empty flag (FIFO_RD_LEVEL_EN)
// -----------------------------------------------------------------------------
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH
`ifdef FIFO_RD_LEVEL_EN
    ,
    parameter int AEMPTY_THRESH = 2
`endif
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH:0]   Rq2_Wptr,
    output logic                     R_en,
    output logic [ADDRESS_WIDTH-1:0] R_addr,
    input  logic [DATA_WIDTH-1:0]    R_mem_data,
    output logic [ADDRESS_WIDTH:0]   R_ptr,
    output logic                     Empty,
    output logic [DATA_WIDTH-1:0]    Dout,
    output logic                     Dout_valid,
    input  logic                     Dout_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDRESS_WIDTH:0]   Rd_level,
    output logic                     AEmpty
`endif
);

    localparam int                PTR_W   = ADDRESS_WIDTH + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rptr_next;
    logic             pend;
    logic             out_valid;
    logic             skid_valid;
    logic             pop;
    logic [1:0]       occ;
    logic [1:0]       occ_after_pop;

    assign rbin_next = rbin + PTR_ONE;
    assign rptr_next = PTR_W'(bin2gray(FIFO_PTR_MAX_W'(rbin_next)));

    assign Empty      = (R_ptr == Rq2_Wptr);
    assign Dout_valid = out_valid;
    assign pop        = out_valid & Dout_ready;
    assign R_addr     = rbin[ADDRESS_WIDTH-1:0];

    // Words held or in flight: out, skid and the read returning next cycle.
    // pop implies out_valid, so the subtraction never underflows.
    assign occ           = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pend};
    assign occ_after_pop = occ - {1'b0, pop};

    // Issue only when the word will have a slot once it returns.
    assign R_en = !RST && !Empty && (occ_after_pop < 2'd2);

    // ---- issue stage: read pointer and in-flight marker ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            rbin  <= '0;
            R_ptr <= '0;
            pend  <= 1'b0;
        end else begin
            pend <= R_en;
            if (R_en) begin
                rbin  <= rbin_next;
                R_ptr <= rptr_next;
            end
        end
    end

    // ---- return stage: memory data into the output buffer ----
    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk        (CLK),
        .rst        (RST),
        .load       (pend),
        .load_data  (R_mem_data),
        .pop        (pop),
        .out_valid  (out_valid),
        .out_data   (Dout),
        .skid_valid (skid_valid)
    );

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_W-1:0] wbin;

    assign wbin     = PTR_W'(gray2bin(FIFO_PTR_MAX_W'(Rq2_Wptr)));
    assign Rd_level = wbin - rbin;
    assign AEmpty   = (FIFO_PTR_MAX_W'(Rd_level) <= FIFO_PTR_MAX_W'(AEMPTY_THRESH));
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
//   Self-checking bench for fifo_read_ctrl. The bench plays the write side:
//   it fills a memory model, advances a Gray write pointer and keeps the
//   written words in an expected-order queue. Every consumer pop is compared
//   against the queue head; directed sections check reset, latency,
//   streaming, backpressure, wrap-around and mid-operation reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_read_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW:0]   Rq2_Wptr;
    logic          R_en;
    logic [AW-1:0] R_addr;
    logic [DW-1:0] R_mem_data = '0;
    logic [AW:0]   R_ptr;
    logic          Empty;
    logic [DW-1:0] Dout;
    logic          Dout_valid;
    logic          Dout_ready;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   Rd_level;
    logic          AEmpty;
`endif

    fifo_read_ctrl #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Rq2_Wptr   (Rq2_Wptr),
        .R_en       (R_en),
        .R_addr     (R_addr),
        .R_mem_data (R_mem_data),
        .R_ptr      (R_ptr),
        .Empty      (Empty),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .Rd_level   (Rd_level),
        .AEmpty     (AEmpty)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model with 1-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (R_en) R_mem_data <= mem[R_addr];
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            wcnt     = 0;   // words written since last reset
    int            fetched  = 0;   // read issues since last reset
    int            popped   = 0;   // words consumed since last reset
    logic [DW-1:0] exp_q [$];
    int            addr_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = AW'(0) + (AW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Write one word: new random data at the next slot, pointer advanced.
    task automatic push_word();
        logic [DW-1:0] d;
        d = DW'($urandom);
        mem[wcnt % (1<<AW)] = d;
        exp_q.push_back(d);
        wcnt++;
        Rq2_Wptr = gray(wcnt % (1 << (AW+1)));
    endtask

    task automatic do_reset(input int cycles);
        RST      = 1'b1;
        Rq2_Wptr = '0;
        wcnt     = 0;
        fetched  = 0;
        popped   = 0;
        exp_q.delete();
        repeat (cycles) tick();
        RST = 1'b0;
    endtask

    task automatic wait_drain(input int target, input int budget);
        int n;
        n = 0;
        while (popped != target && n < budget) begin
            tick();
            n++;
        end
        check("drain", 32'(popped), 32'(target));
    endtask

    // Scoreboard: order/loss/duplication and buffer occupancy bound.
    always @(negedge CLK) begin
        if (!RST) begin
            if (Dout_valid && Dout_ready) begin
                check("word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("dout", 32'(Dout), 32'(exp_q.pop_front()));
                popped++;
            end
            if (R_en) begin
                fetched++;
                addr_log.push_back(int'(R_addr));
                check("occupancy", 32'(fetched - popped <= 2), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w0;
        int            pushed;
        int            guard;

        RST        = 1'b1;
        Rq2_Wptr   = '0;
        Dout_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_empty", 32'(Empty), 1);
        check("rst_ren", 32'(R_en), 0);
        check("rst_valid", 32'(Dout_valid), 0);
        check("rst_rptr", 32'(R_ptr), 0);
        check("rst_dout", 32'(Dout), 0);
        RST = 1'b0;
        tick();

        // Single word latency
        Dout_ready = 1'b1;
        push_word();
        w0 = mem[0];
        #1;
        check("single_ren", 32'(R_en), 1);
        check("single_addr", 32'(R_addr), 0);
        tick();
        check("single_rptr", 32'(R_ptr), 32'h01);
        check("single_empty", 32'(Empty), 1);
        check("single_ren_off", 32'(R_en), 0);
        check("single_valid_early", 32'(Dout_valid), 0);
        tick();
        check("single_valid", 32'(Dout_valid), 1);
        check("single_dout", 32'(Dout), 32'(w0));
        tick();
        check("single_valid_once", 32'(Dout_valid), 0);

        // Streaming 16 back-to-back words from reset
        do_reset(2);
        Dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word();
        check("stream_wptr", 32'(Rq2_Wptr), 32'h18);
        repeat (2) tick();
        for (int i = 0; i < 16; i++) begin
            check("stream_beat", 32'(Dout_valid), 1);
            tick();
        end
        check("stream_end_valid", 32'(Dout_valid), 0);
        check("stream_rptr", 32'(R_ptr), 32'h18);
        check("stream_empty", 32'(Empty), 1);
        check("stream_ren", 32'(R_en), 0);
        check("stream_count", 32'(popped), 16);

        // Backpressure: only two fetches while the consumer stalls
        do_reset(2);
        Dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word();
        repeat (8) tick();
        check("bp_fetches", 32'(fetched), 2);
        check("bp_valid", 32'(Dout_valid), 1);
        Dout_ready = 1'b1;
        wait_drain(4, 50);
        check("bp_leftover", 32'(exp_q.size()), 0);

        // Toggling ready with a steady supply
        for (int i = 0; i < 40; i++) begin
            if (wcnt - popped < 16) push_word();
            Dout_ready = ~Dout_ready;
            tick();
        end
        Dout_ready = 1'b1;
        wait_drain(wcnt, 100);

        // Random supply and backpressure
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0 && (wcnt - popped) < 16) push_word();
            Dout_ready = 1'($urandom);
            tick();
        end
        Dout_ready = 1'b1;
        wait_drain(wcnt, 200);
        check("rand_leftover", 32'(exp_q.size()), 0);
        check("rand_fetched", 32'(fetched), 32'(wcnt));

        // Wrap-around: read pointer 30, write pointer 34 (mod 32 = 2)
        do_reset(2);
        Dout_ready = 1'b1;
        pushed = 0;
        guard  = 0;
        while (pushed < 30 && guard < 500) begin
            if (wcnt - popped < 16) begin
                push_word();
                pushed++;
            end
            tick();
            guard++;
        end
        wait_drain(30, 100);
        addr_log.delete();
        for (int i = 0; i < 4; i++) push_word();
        check("wrap_wptr", 32'(Rq2_Wptr), 32'(gray(2)));
        wait_drain(34, 50);
        check("wrap_addr_count", 32'(addr_log.size()), 4);
        if (addr_log.size() == 4) begin
            check("wrap_addr0", 32'(addr_log[0]), 14);
            check("wrap_addr1", 32'(addr_log[1]), 15);
            check("wrap_addr2", 32'(addr_log[2]), 0);
            check("wrap_addr3", 32'(addr_log[3]), 1);
        end
        check("wrap_rptr", 32'(R_ptr), 32'(gray(2)));

        // Reset while the buffer is full and the consumer stalls
        Dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word();
        repeat (4) tick();
        check("full_valid", 32'(Dout_valid), 1);
        check("full_outstanding", 32'(fetched - popped), 2);
        RST      = 1'b1;
        Rq2_Wptr = '0;
        wcnt     = 0;
        fetched  = 0;
        popped   = 0;
        exp_q.delete();
        #1;
        check("midrst_ren_now", 32'(R_en), 0);
        tick();
        check("midrst_valid", 32'(Dout_valid), 0);
        check("midrst_rptr", 32'(R_ptr), 0);
        check("midrst_ren", 32'(R_en), 0);
        tick();
        RST = 1'b0;
        #1;
        check("midrst_empty", 32'(Empty), 1);

`ifdef FIFO_RD_LEVEL_EN
        // Level and almost-empty
        do_reset(2);
        Dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word();
        #1;
        check("lvl_wptr", 32'(Rq2_Wptr), 32'h02);
        check("lvl_level3", 32'(Rd_level), 3);
        check("lvl_aempty0", 32'(AEmpty), 0);
        tick();
        check("lvl_level2", 32'(Rd_level), 2);
        check("lvl_aempty1", 32'(AEmpty), 1);
        do_reset(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
- Read-side controller of the async FIFO, living entirely in the read clock domain.
- Takes the 2-flop-synchronized Gray write pointer and sequences reads from the dual-port FIFO memory, which has 1-cycle read latency.
- Generates the binary read address and Gray read pointer (sent to the write-domain synchronizer), plus the Empty flag.
- Presents data to the consumer over a valid/ready interface, backed by a 2-entry output buffer that sustains one word per cycle.

Parameters:
- ADDRESS_WIDTH, 4, memory address bits; FIFO depth = 2^ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits.
- DATA_WIDTH, 8, width of one FIFO word.
- AEMPTY_THRESH, 2, almost-empty threshold (only used with the optional feature).

Ports:
- CLK  in  1  read-domain clock.
- RST  in  1  synchronous, active-high reset.
- Rq2_Wptr  in  ADDRESS_WIDTH+1  synchronized Gray write pointer.
- R_en  out  1  memory read enable.
- R_addr  out  ADDRESS_WIDTH  memory read address.
- R_mem_data  in  DATA_WIDTH  memory read data, valid the cycle after R_en.
- R_ptr  out  ADDRESS_WIDTH+1  registered Gray read pointer, to the write-domain synchronizer.
- Empty  out  1  no unread entries in memory.
- Dout  out  DATA_WIDTH  output data.
- Dout_valid  out  1  Dout holds a valid word.
- Dout_ready  in  1  consumer accepts Dout.

Behaviour:
- Reset, sampled on the CLK edge while RST=1, clears:
  - rbin=0, R_ptr=0, pend=0.
  - out_valid=0, skid_valid=0, Dout=0.
  - R_en is forced 0 for the whole cycle in which RST=1.
- Reset asserted mid-operation discards in-flight and buffered data; there is no drain.
- Empty is combinational: Empty = (R_ptr == Rq2_Wptr).
- pop = Dout_valid & Dout_ready. Dout_valid = out_valid.
- Occupancy: occ = out_valid + skid_valid + pend.
- Issue rule:
  - R_en = !RST & !Empty & (occ - pop < 2).
  - R_addr = rbin[ADDRESS_WIDTH-1:0].
- On R_en:
  - rbin <= rbin+1, wrapping modulo 2^(ADDRESS_WIDTH+1).
  - R_ptr <= bin2gray(rbin+1).
  - pend <= 1. Otherwise pend <= 0.
- Data return (pend=1) and pop in the same cycle:
  - If out is free after the pop, R_mem_data goes to out; otherwise it goes to skid.
  - On pop with skid_valid=1, skid moves to out and skid_valid clears (unless the return refills skid).
  - Words are delivered strictly in pointer order; never lost, never duplicated.
- Latency: Empty falls in cycle t → R_en in t → R_mem_data in t+1 → Dout_valid=1 in t+2.
- Steady-state throughput: 1 word/cycle while Dout_ready=1 and the FIFO is non-empty.
- Backpressure: with Dout_ready=0, at most 2 words are fetched (out+skid, or out+pend); further reads stall.
- Wrap-around: the pointer MSB distinguishes laps, so an address wrap (2^ADDRESS_WIDTH-1 → 0) is transparent.
- Rq2_Wptr changes asynchronously to the consumer. Empty releasing and a pop in the same cycle follow the issue rule with no special case.

Optional Feature:
- FIFO_RD_LEVEL_EN defined:
  - Adds output Rd_level [ADDRESS_WIDTH:0] = gray2bin(Rq2_Wptr) - rbin (mod 2^(ADDRESS_WIDTH+1)). This counts entries not yet fetched from memory, excluding buffered words.
  - Adds output AEmpty = (Rd_level <= AEMPTY_THRESH).
  - Both are combinational from registered state.
- FIFO_RD_LEVEL_EN undefined: neither port exists and no gray2bin logic is instantiated.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDRESS_WIDTH and DATA_WIDTH constants;
  - bin2gray and gray2bin functions, also used by the write-side controller.
- Sub-module fifo_out_buf: 2-entry out/skid buffer with valid/ready, load and pop ports.
- Pointer/empty logic and the issue rule stay in the top module.

Test Plan:
- Reset: RST=1 for 2 cycles with Rq2_Wptr=0 → Empty=1, R_en=0, Dout_valid=0, R_ptr=00000, Dout=0.
- Single word: Rq2_Wptr 00000→00001 at cycle t, Dout_ready=1 → R_en=1, R_addr=0 at t; R_ptr=00001 and Empty=1 at t+1; Dout_valid=1 with Dout=mem[0] at t+2, for exactly one cycle.
- Streaming: Rq2_Wptr=11000 (gray 16), Dout_ready=1 → 16 back-to-back beats mem[0..15] in order; R_ptr ends at 11000; Empty=1; no further R_en.
- Backpressure: 4 words available, Dout_ready=0 → exactly 2 R_en pulses, then stall. Release Dout_ready → words 0..3 delivered once each, in order. Toggling Dout_ready every cycle → no loss or duplication.
- Wrap and reset: rbin=30, Rq2_Wptr=gray(2) → R_addr sequence 14,15,0,1 with correct data. Then RST=1 while buffer full and Dout_ready=0 → next cycle Dout_valid=0, R_ptr=0, R_en=0.
- FIFO_RD_LEVEL_EN: rbin=0, Rq2_Wptr=gray(3)=00010 → Rd_level=3, AEmpty=0. After one read → Rd_level=2, AEmpty=1.
